// File: rtl/pifo_task_ingress.sv
// Multi-lane PIFO ingress: pairs per-level push/pop requests into task words and
// queues them per lane behind a show-ahead FIFO with drop accounting and latch flush.
module pifo_task_ingress #(
    parameter int CH       = 4,
    parameter int DW       = 18,
    parameter int TREE_NUM = 4,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 16,
    parameter int DCW      = 16,
    localparam int TID_W   = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
    localparam int CW      = $clog2(DEPTH) + 1,
    localparam int TW      = 2 + 2 * TID_W + DW
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic [CH-1:0]    i_push,
    input  logic [TID_W-1:0] i_push_tree_id [0:CH-1],
    input  logic [DW-1:0]    i_push_data    [0:CH-1],
    input  logic [CH-1:0]    i_pop,
    input  logic [TID_W-1:0] i_pop_tree_id  [0:CH-1],
    output logic [CH-1:0]    o_ready,
    output logic [CH-1:0]    o_task_valid,
    input  logic [CH-1:0]    i_task_ready,
    output logic [TW-1:0]    o_task         [0:CH-1],
    output logic [CW-1:0]    o_fifo_count   [0:CH-1],
    output logic [DCW-1:0]   o_drop_cnt     [0:CH-1],
    output logic [CH-1:0]    o_overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TMW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        logic             latch_q, latch_d;
        logic [TID_W-1:0] ltid_q, ltid_d;
        logic [DW-1:0]    ldata_q, ldata_d;
        logic [TMW-1:0]   timer_q, timer_d;
        logic [TW-1:0]    mem [DEPTH];
        logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
        logic [CW-1:0]    count_q;
        logic [DCW-1:0]   drop_q;
        logic             ovf_q;
        logic             full, req, accept, drop, wr_en, rd_en;
        logic [TW-1:0]    wr_data;

        always_comb begin
            full    = (count_q == CW'(DEPTH));
            req     = i_push[g] | i_pop[g];
            accept  = req & ~full;
            drop    = req & full;
            rd_en   = (count_q != '0) & i_task_ready[g];
            wr_en   = 1'b0;
            wr_data = '0;
            latch_d = latch_q;
            ltid_d  = ltid_q;
            ldata_d = ldata_q;
            timer_d = timer_q;
            if (accept) begin
                if (latch_q) begin
                    // The latched push always leaves; a new push takes its place.
                    wr_en   = 1'b1;
                    wr_data = {1'b1, i_pop[g], ltid_q, i_pop_tree_id[g], ldata_q};
                    if (i_push[g]) begin
                        ltid_d  = i_push_tree_id[g];
                        ldata_d = i_push_data[g];
                        timer_d = '0;
                    end else begin
                        latch_d = 1'b0;
                    end
                end else if (i_pop[g]) begin
                    wr_en   = 1'b1;
                    wr_data = {i_push[g], 1'b1, i_push_tree_id[g], i_pop_tree_id[g], i_push_data[g]};
                end else begin
                    latch_d = 1'b1;
                    ltid_d  = i_push_tree_id[g];
                    ldata_d = i_push_data[g];
                    timer_d = '0;
                end
            end else if (latch_q && TIMEOUT != 0) begin
                // At the last timer value the flush retries each cycle until space frees up.
                if (timer_q == TMW'(TLAST)) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        wr_data = {1'b1, 1'b0, ltid_q, {TID_W{1'b0}}, ldata_q};
                        latch_d = 1'b0;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                latch_q  <= 1'b0;
                ltid_q   <= '0;
                ldata_q  <= '0;
                timer_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                drop_q   <= '0;
                ovf_q    <= 1'b0;
            end else begin
                latch_q <= latch_d;
                ltid_q  <= ltid_d;
                ldata_q <= ldata_d;
                timer_q <= timer_d;
                if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(wr_en) - CW'(rd_en);
                if (drop) begin
                    if (drop_q != '1) drop_q <= drop_q + DCW'(1);
                    ovf_q <= 1'b1;
                end
            end
        end

        // Storage needs no reset: the head is gated to zero while the FIFO is empty.
        always_ff @(posedge i_clk) begin
            if (wr_en) mem[wr_ptr_q] <= wr_data;
        end

        assign o_ready[g]      = ~full;
        assign o_task_valid[g] = (count_q != '0);
        assign o_task[g]       = (count_q != '0) ? mem[rd_ptr_q] : '0;
        assign o_fifo_count[g] = count_q;
        assign o_drop_cnt[g]   = drop_q;
        assign o_overflow[g]   = ovf_q;
    end

endmodule

// File: tb/tb_pifo_task_ingress.sv
// Directed and randomized checks of pifo_task_ingress with a per-lane expected-task scoreboard.
module tb_pifo_task_ingress;
    localparam int CH = 4, DW = 18, TID_W = 2, DEPTH = 8, TIMEOUT = 16, DCW = 16;
    localparam int CW = 4, TW = 24;

    logic             clk;
    logic             rst_n;
    logic [CH-1:0]    i_push, i_pop, i_task_ready;
    logic [TID_W-1:0] i_push_tree_id [0:CH-1];
    logic [DW-1:0]    i_push_data    [0:CH-1];
    logic [TID_W-1:0] i_pop_tree_id  [0:CH-1];
    logic [CH-1:0]    o_ready, o_task_valid, o_overflow;
    logic [TW-1:0]    o_task       [0:CH-1];
    logic [CW-1:0]    o_fifo_count [0:CH-1];
    logic [DCW-1:0]   o_drop_cnt   [0:CH-1];

    pifo_task_ingress #(
        .CH(CH), .DW(DW), .TREE_NUM(4), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DCW(DCW)
    ) dut (
        .i_clk(clk), .i_arst_n(rst_n),
        .i_push(i_push), .i_push_tree_id(i_push_tree_id), .i_push_data(i_push_data),
        .i_pop(i_pop), .i_pop_tree_id(i_pop_tree_id),
        .o_ready(o_ready), .o_task_valid(o_task_valid), .i_task_ready(i_task_ready),
        .o_task(o_task), .o_fifo_count(o_fifo_count), .o_drop_cnt(o_drop_cnt),
        .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [TW-1:0] exp_q [CH][$];
    logic [TW-1:0] mon_e;

    // Reference lane model for the random phase
    logic          m_l    [CH];
    logic [1:0]    m_tid  [CH];
    logic [DW-1:0] m_data [CH];
    int            m_idle [CH];
    int            pct    [CH] = '{60, 40, 20, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk(input logic pu, input logic po, input logic [1:0] pt,
                                         input logic [1:0] qt, input logic [DW-1:0] d);
        return {pu, po, pt, qt, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_push = '0;
        i_pop  = '0;
        for (int l = 0; l < CH; l++) begin
            i_push_tree_id[l] = '0;
            i_push_data[l]    = '0;
            i_pop_tree_id[l]  = '0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'hF);
        chk({tag, "_valid"}, 32'(o_task_valid), 32'h0);
        chk({tag, "_overflow"}, 32'(o_overflow), 32'h0);
        for (int l = 0; l < CH; l++) begin
            chk($sformatf("%s_task_l%0d", tag, l), 32'(o_task[l]), 32'h0);
            chk($sformatf("%s_count_l%0d", tag, l), 32'(o_fifo_count[l]), 32'h0);
            chk($sformatf("%s_drop_l%0d", tag, l), 32'(o_drop_cnt[l]), 32'h0);
        end
    endtask

    // Monitor: a task is consumed at the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < CH; l++) begin
                if (o_task_valid[l] && i_task_ready[l]) begin
                    if (exp_q[l].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_task lane=%0d actual=0x%0h expected=none", l, o_task[l]);
                    end else begin
                        mon_e = exp_q[l].pop_front();
                        chk($sformatf("task_l%0d", l), 32'(o_task[l]), 32'(mon_e));
                    end
                end
            end
        end
    end

    task automatic rand_cycle(input bit allow_req);
        int k;
        logic pu, po;
        for (int l = 0; l < CH; l++) begin
            pu = 1'b0;
            po = 1'b0;
            if (allow_req && $urandom_range(0, 99) < pct[l]) begin
                k  = $urandom_range(0, 4);
                pu = (k == 0 || k == 1 || k == 4);
                po = (k >= 2);
            end
            i_push[l]         = pu;
            i_pop[l]          = po;
            i_push_tree_id[l] = 2'($urandom_range(0, 3));
            i_pop_tree_id[l]  = 2'($urandom_range(0, 3));
            i_push_data[l]    = 18'($urandom);
            if (pu || po) begin
                if (m_l[l]) begin
                    exp_q[l].push_back(mk(1'b1, po, m_tid[l], i_pop_tree_id[l], m_data[l]));
                    if (pu) begin
                        m_tid[l]  = i_push_tree_id[l];
                        m_data[l] = i_push_data[l];
                        m_idle[l] = 0;
                    end else begin
                        m_l[l] = 1'b0;
                    end
                end else if (po) begin
                    exp_q[l].push_back(mk(pu, 1'b1, i_push_tree_id[l], i_pop_tree_id[l], i_push_data[l]));
                end else begin
                    m_l[l]    = 1'b1;
                    m_tid[l]  = i_push_tree_id[l];
                    m_data[l] = i_push_data[l];
                    m_idle[l] = 0;
                end
            end else if (m_l[l]) begin
                m_idle[l]++;
                if (m_idle[l] == TIMEOUT) begin
                    exp_q[l].push_back(mk(1'b1, 1'b0, m_tid[l], 2'd0, m_data[l]));
                    m_l[l] = 1'b0;
                end
            end
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        i_task_ready = '0;
        for (int l = 0; l < CH; l++) begin
            m_l[l] = 1'b0; m_tid[l] = '0; m_data[l] = '0; m_idle[l] = 0;
        end
        repeat (3) step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();
        chk_reset("post_rst");

        // Push latched, paired with a pop three cycles later
        i_push[0] = 1'b1; i_push_tree_id[0] = 2'd2; i_push_data[0] = 18'h155;
        step();
        clear_inputs();
        chk("t1_latched_no_task", 32'(o_task_valid[0]), 32'h0);
        step(); step();
        i_pop[0] = 1'b1; i_pop_tree_id[0] = 2'd1;
        exp_q[0].push_back(mk(1'b1, 1'b1, 2'd2, 2'd1, 18'h155));
        step();
        clear_inputs();
        chk("t1_valid", 32'(o_task_valid[0]), 32'h1);
        chk("t1_task", 32'(o_task[0]), 32'(mk(1'b1, 1'b1, 2'd2, 2'd1, 18'h155)));
        chk("t1_count", 32'(o_fifo_count[0]), 32'h1);
        step(); step();
        chk("t1_count_held", 32'(o_fifo_count[0]), 32'h1);
        i_task_ready[0] = 1'b1;
        step();
        chk("t1_count_consumed", 32'(o_fifo_count[0]), 32'h0);

        // Pop alone, then push and pop together
        i_pop[0] = 1'b1; i_pop_tree_id[0] = 2'd3;
        exp_q[0].push_back(mk(1'b0, 1'b1, 2'd0, 2'd3, 18'h0));
        step();
        clear_inputs();
        chk("t2_pop_valid", 32'(o_task_valid[0]), 32'h1);
        chk("t2_pop_task", 32'(o_task[0]), 32'(mk(1'b0, 1'b1, 2'd0, 2'd3, 18'h0)));
        i_push[0] = 1'b1; i_pop[0] = 1'b1;
        i_push_tree_id[0] = 2'd1; i_pop_tree_id[0] = 2'd2; i_push_data[0] = 18'h2AA;
        exp_q[0].push_back(mk(1'b1, 1'b1, 2'd1, 2'd2, 18'h2AA));
        step();
        clear_inputs();
        chk("t2_pushpop_task", 32'(o_task[0]), 32'(mk(1'b1, 1'b1, 2'd1, 2'd2, 18'h2AA)));
        chk("t2_count", 32'(o_fifo_count[0]), 32'h1);
        step();

        // Back-to-back pushes: A goes out push-only, B is flushed after TIMEOUT
        i_push[0] = 1'b1; i_push_tree_id[0] = 2'd1; i_push_data[0] = 18'h011;
        step();
        i_push_tree_id[0] = 2'd3; i_push_data[0] = 18'h033;
        exp_q[0].push_back(mk(1'b1, 1'b0, 2'd1, 2'd0, 18'h011));
        step();
        clear_inputs();
        chk("t3_a_valid", 32'(o_task_valid[0]), 32'h1);
        repeat (15) step();
        chk("t3_no_early_flush", 32'(o_task_valid[0]), 32'h0);
        exp_q[0].push_back(mk(1'b1, 1'b0, 2'd3, 2'd0, 18'h033));
        step();
        chk("t3_flush_valid", 32'(o_task_valid[0]), 32'h1);
        step();

        // Ten pops against a stalled distributor
        i_task_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_pop[0] = 1'b1;
            i_pop_tree_id[0] = 2'(i % 4);
            if (i < 8) exp_q[0].push_back(mk(1'b0, 1'b1, 2'd0, 2'(i % 4), 18'h0));
            step();
            if (i == 7) begin
                chk("t4_count_full", 32'(o_fifo_count[0]), 32'h8);
                chk("t4_ready_low", 32'(o_ready[0]), 32'h0);
            end
        end
        clear_inputs();
        chk("t4_drop_cnt", 32'(o_drop_cnt[0]), 32'h2);
        chk("t4_overflow", 32'(o_overflow), 32'h1);
        chk("t4_count", 32'(o_fifo_count[0]), 32'h8);
        chk("t4_other_lane_drop", 32'(o_drop_cnt[1]), 32'h0);
        i_task_ready[0] = 1'b1;
        step();
        chk("t4_ready_back", 32'(o_ready[0]), 32'h1);
        chk("t4_count_7", 32'(o_fifo_count[0]), 32'h7);
        repeat (8) step();
        chk("t4_drained", 32'(o_fifo_count[0]), 32'h0);

        // Full FIFO with an expired latch: flush waits for space
        i_task_ready[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            i_push[0] = 1'b1;
            i_push_tree_id[0] = 2'(i);
            i_push_data[0] = 18'(i * 16 + 5);
            if (i >= 1) exp_q[0].push_back(mk(1'b1, 1'b0, 2'(i - 1), 2'd0, 18'((i - 1) * 16 + 5)));
            step();
        end
        clear_inputs();
        chk("t5_count_full", 32'(o_fifo_count[0]), 32'h8);
        repeat (20) step();
        chk("t5_flush_held", 32'(o_fifo_count[0]), 32'h8);
        chk("t5_no_new_drops", 32'(o_drop_cnt[0]), 32'h2);
        i_task_ready[0] = 1'b1;
        step();
        i_task_ready[0] = 1'b0;
        chk("t5_count_released", 32'(o_fifo_count[0]), 32'h7);
        chk("t5_ready_released", 32'(o_ready[0]), 32'h1);
        exp_q[0].push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 18'd133));
        step();
        chk("t5_flush_refill", 32'(o_fifo_count[0]), 32'h8);
        i_task_ready[0] = 1'b1;
        repeat (9) step();
        chk("t5_drained", 32'(o_fifo_count[0]), 32'h0);
        chk("t5_queue_empty", 32'(exp_q[0].size()), 32'h0);

        // Random traffic on all lanes with a reset in the middle
        i_task_ready = '1;
        for (int c = 0; c < 150; c++) rand_cycle(1'b1);
        clear_inputs();
        rst_n = 1'b0;
        for (int l = 0; l < CH; l++) begin
            exp_q[l].delete();
            m_l[l] = 1'b0;
            m_idle[l] = 0;
        end
        #1;
        chk_reset("rst_mid_async");
        step();
        chk_reset("rst_mid");
        rst_n = 1'b1;
        step();
        chk_reset("rst_after");
        for (int c = 0; c < 150; c++) rand_cycle(1'b1);
        for (int c = 0; c < 40; c++) rand_cycle(1'b0);
        for (int l = 0; l < CH; l++)
            chk($sformatf("final_queue_empty_l%0d", l), 32'(exp_q[l].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pifo_task_ingress.md
# pifo_task_ingress

Multi-lane ingress front-end for the PIFO tree. It coalesces per-level push and pop requests into task words and buffers them in per-lane task FIFOs. Tasks are presented to the task distributor over a valid/ready handshake. Over the current fixed front-end it adds a parameterised lane count and depth, upstream backpressure, drop accounting, and a timeout that flushes a latched push which no pop ever pairs with.

## Interface
Parameters:
- CH, 4: number of independent lanes (one per PIFO level/RPU).
- DW, 18: push data width (MTW+PTW+PLW).
- TREE_NUM, 4: number of trees; TID_W = $clog2(TREE_NUM).
- DEPTH, 8: task FIFO entries per lane (power of 2, ≥2); CW = $clog2(DEPTH)+1.
- TIMEOUT, 16: idle cycles before a latched push is flushed alone; 0 disables flushing.
- DCW, 16: drop counter width.
- Derived: TW = 2 + 2*TID_W + DW, the task word width.

Ports (unpacked arrays are [0:CH-1]):
- i_clk  in  1  clock.
- i_arst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_push  in  [CH-1:0]  push request per lane.
- i_push_tree_id  in  TID_W ×CH  tree of the push.
- i_push_data  in  DW ×CH  push metadata/payload/length.
- i_pop  in  [CH-1:0]  pop request per lane.
- i_pop_tree_id  in  TID_W ×CH  tree of the pop.
- o_ready  out  [CH-1:0]  lane accepts requests this cycle.
- o_task_valid  out  [CH-1:0]  task available at the FIFO head.
- i_task_ready  in  [CH-1:0]  distributor consumes the head task.
- o_task  out  TW ×CH  task word {push, pop, push_tid, pop_tid, data}, with the push bit as MSB.
- o_fifo_count  out  CW ×CH  occupancy.
- o_drop_cnt  out  DCW ×CH  saturating count of dropped request cycles.
- o_overflow  out  [CH-1:0]  sticky flag, set on the first drop.

## Operation
Lanes are fully independent. Per lane, the state is: latch valid L, latched tid/data, a flush timer of width $clog2(TIMEOUT+1), FIFO storage, and read/write pointers.

Accepted cycle: o_ready=1 and (i_push|i_pop). The decode on {L, i_push, i_pop} is:
- 0,0,0: idle.
- 0,x,1: enqueue {i_push, 1, i_push_tree_id, i_pop_tree_id, i_push_data}. L stays 0.
- 0,1,0: latch the push (L←1, timer←0). Nothing is enqueued.
- 1,0,1: enqueue {1, 1, latched tid, i_pop_tree_id, latched data}; L←0.
- 1,1,x: enqueue {1, i_pop, latched tid, i_pop_tree_id, latched data}. The new push is latched and the timer is cleared.
- 1,0,0: timer increments; see flush.

Flush rule:
- Applies when L=1, there is no accepted request this cycle, TIMEOUT≠0, timer==TIMEOUT-1, and the FIFO is not full.
- Action: enqueue {1, 0, latched tid, 0, latched data}; L←0.
- If the FIFO is full, the timer holds at TIMEOUT-1 and the flush retries every cycle.

Backpressure and drops:
- o_ready = (count < DEPTH), decoded from registered state only.
- A request cycle with o_ready=0 is dropped: latch and FIFO are unchanged, o_drop_cnt increments and saturates at all-ones, and o_overflow sets.
- Every accepted path writes at most one FIFO entry per cycle, so o_ready never needs lookahead.

FIFO and handshake:
- The FIFO is show-ahead: o_task is the head entry and o_task_valid = (count≠0).
- A pop occurs when o_task_valid & i_task_ready; i_task_ready without valid is ignored.
- Simultaneous read and write leave count unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Input to o_task_valid latency: 1 cycle. A task enqueued at edge n is visible after edge n (empty-FIFO case).
- A latched push with no pop is flushed TIMEOUT cycles after the cycle it was latched, and is visible 1 cycle later.
- o_ready is deasserted in the cycle count reaches DEPTH. It reasserts the cycle after the first consume.
- Reset values: o_ready all 1, o_task_valid 0, o_task 0, o_fifo_count 0, o_drop_cnt 0, o_overflow 0, L 0, timer 0.
- Asserting reset mid-operation discards the latch and all FIFO contents, and clears counters and flags.

## Test plan
- Lane 0: push (tid 2, data 0x155) at cycle 0, then pop (tid 1) at cycle 3 → single task {1,1,2,1,0x155}, valid at cycle 4. Count stays 1 until consumed.
- Pop alone (tid 3) with L=0 → task {0,1,0,3,0} after 1 cycle. Push+pop in the same cycle → one task with both bits set and the current data.
- Two back-to-back pushes (A, B) with no pop, TIMEOUT=16 → A enqueued at the second push as push-only. B is flushed push-only 16 cycles later.
- Hold i_task_ready=0 and issue 10 pops → count reaches 8, o_ready=0, drop_cnt=2, o_overflow=1. Then one consume → o_ready=1 next cycle.
- FIFO full with L=1 and timer expired → no enqueue, timer held. Release one entry → flush enqueued the same cycle, count returns to 8.
- All 4 lanes with independent random traffic plus reset asserted mid-burst → every lane's ordering matches the scoreboard, and all outputs are at reset values during and after reset.
